sopc_v3_nios2_gen2_0_cpu_debug_host_jtag: RTL and testbench



---
 rtl/sopc_v3_nios2_gen2_0_cpu_debug_host_jtag.sv | 162 ++++++++++++++++
 tb/tb_sopc_v3_nios2_gen2_0_cpu_debug_host_jtag.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sopc_v3_nios2_gen2_0_cpu_debug_host_jtag.sv
// rtl/sopc_v3_nios2_gen2_0_cpu_debug_host_jtag.sv - system-clock virtual JTAG host engine for the Nios II debug slave
//
// Purpose: accepts one command (virtual IR + DR payload), walks the virtual TAP
// through UIR, CDR, SDR x DR_WIDTH, UDR, RTI on a divided TCK, shifts the payload
// out LSB first on TDI and returns the DR_WIDTH bits captured from TDO.
//
// Ports:
//   clk, reset_n                   system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake; cmd_ir/cmd_dr latched on accept
//   rsp_valid, rsp_data            one-cycle response pulse, data held until next response
//   vji_tck, vji_tdi, vji_tdo      generated TCK and serial data to/from the slave
//   vji_ir_in                      virtual IR presented to the slave
//   vji_uir/cdr/sdr/udr/rti        virtual TAP state flags
module sopc_v3_nios2_gen2_0_cpu_debug_host_jtag #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CW = $clog2(DR_WIDTH + 1);
  localparam int HW = $clog2(TCK_DIV + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DR_WIDTH - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(TCK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI
  } state_t;

  state_t              state_q;
  logic [HW-1:0]       half_q;
  logic [CW-1:0]       bit_q;
  logic [DR_WIDTH-1:0] tx_sr_q;
  logic [DR_WIDTH-1:0] rx_q;
  logic [DR_WIDTH-1:0] rsp_data_q;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic                tck_q, tdi_q, rsp_valid_q, cmd_ready_q;
  logic                uir_q, cdr_q, sdr_q, udr_q, rti_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      half_q      <= '0;
      bit_q       <= '0;
      tx_sr_q     <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      ir_in_q     <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            ir_in_q     <= cmd_ir;
            tx_sr_q     <= cmd_dr;
            state_q     <= ST_UIR;
            uir_q       <= 1'b1;
            rti_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            half_q      <= '0;
            tck_q       <= 1'b0;
          end
        end
        default: begin
          if (half_q == HALF_LAST) begin
            half_q <= '0;
            if (!tck_q) begin
              // Rising TCK: TDO is sampled with the value the slave held during the low half.
              // Bits enter at the top so the first sample ends up in bit 0.
              tck_q <= 1'b1;
              if (state_q == ST_SDR) begin
                rx_q <= {vji_tdo, rx_q[DR_WIDTH-1:1]};
              end
            end else begin
              // Falling TCK closes the period: advance state, flags and TDI together.
              tck_q <= 1'b0;
              case (state_q)
                ST_UIR: begin
                  state_q <= ST_CDR;
                  uir_q   <= 1'b0;
                  cdr_q   <= 1'b1;
                end
                ST_CDR: begin
                  state_q <= ST_SDR;
                  cdr_q   <= 1'b0;
                  sdr_q   <= 1'b1;
                  tdi_q   <= tx_sr_q[0];
                  bit_q   <= '0;
                end
                ST_SDR: begin
                  if (bit_q == BIT_LAST) begin
                    state_q <= ST_UDR;
                    sdr_q   <= 1'b0;
                    udr_q   <= 1'b1;
                    tdi_q   <= 1'b0;
                  end else begin
                    bit_q   <= bit_q + CW'(1);
                    tx_sr_q <= tx_sr_q >> 1;
                    tdi_q   <= tx_sr_q[1];
                  end
                end
                ST_UDR: begin
                  state_q <= ST_RTI;
                  udr_q   <= 1'b0;
                  rti_q   <= 1'b1;
                end
                ST_RTI: begin
                  state_q     <= ST_IDLE;
                  rsp_data_q  <= rx_q;
                  rsp_valid_q <= 1'b1;
                  cmd_ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
              endcase
            end
          end else begin
            half_q <= half_q + HW'(1);
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_in_q;
  assign vji_uir   = uir_q;
  assign vji_cdr   = cdr_q;
  assign vji_sdr   = sdr_q;
  assign vji_udr   = udr_q;
  assign vji_rti   = rti_q;

endmodule

// File: tb/tb_sopc_v3_nios2_gen2_0_cpu_debug_host_jtag.sv
// tb/tb_sopc_v3_nios2_gen2_0_cpu_debug_host_jtag.sv - directed bench for the virtual JTAG host engine
module tb_sopc_v3_nios2_gen2_0_cpu_debug_host_jtag;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_valid1 = 1'b0;
  logic [1:0]  cmd_ir = 2'b00;
  logic [37:0] cmd_dr = '0;

  logic        cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_tdo;
  logic [37:0] rsp_data;
  logic [1:0]  vji_ir_in;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  logic        cmd_ready1, rsp_valid1, vji_tck1, vji_tdi1, vji_tdo1;
  logic [37:0] rsp_data1;
  logic [1:0]  vji_ir_in1;
  logic        vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1;

  sopc_v3_nios2_gen2_0_cpu_debug_host_jtag dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
    .vji_rti(vji_rti)
  );

  sopc_v3_nios2_gen2_0_cpu_debug_host_jtag #(.IR_WIDTH(2), .DR_WIDTH(38), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
    .vji_tck(vji_tck1), .vji_tdi(vji_tdi1), .vji_tdo(vji_tdo1), .vji_ir_in(vji_ir_in1),
    .vji_uir(vji_uir1), .vji_cdr(vji_cdr1), .vji_sdr(vji_sdr1), .vji_udr(vji_udr1),
    .vji_rti(vji_rti1)
  );

  // Slave models: 38-bit shifters clocked on TCK rising while in SDR, TDO = bit 0.
  logic [37:0] model_sr, model_init = '0;
  logic        model_ld = 1'b0;
  always @(posedge vji_tck or posedge model_ld)
    if (model_ld) model_sr <= model_init;
    else if (vji_sdr) model_sr <= {vji_tdi, model_sr[37:1]};
  assign vji_tdo = model_sr[0];

  logic [37:0] model1_sr;
  logic        model1_ld = 1'b0;
  always @(posedge vji_tck1 or posedge model1_ld)
    if (model1_ld) model1_sr <= model_init;
    else if (vji_sdr1) model1_sr <= {vji_tdi1, model1_sr[37:1]};
  assign vji_tdo1 = model1_sr[0];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          rsp_cyc;
  logic [37:0] rsp_val, udr_model;
  int          edges[5];
  bit          order_ok, proto_ok;
  logic        uir_at1;
  logic [1:0]  ir_at1;

  // Presents a command in the current cycle (cycle 0) and steps until the response.
  task automatic run_cmd(input logic [1:0] ir, input logic [37:0] dr, input int busy_at);
    int code, last_code, sdr_edges;
    bit prev_tck, udr_seen, busy_on;
    cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
    rsp_cyc = -1; order_ok = 1; proto_ok = 1; udr_seen = 0; busy_on = 0;
    last_code = 0; sdr_edges = 0; prev_tck = 0; udr_model = '0; rsp_val = '0;
    for (int i = 0; i < 5; i++) edges[i] = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin cmd_valid = 1'b0; uir_at1 = vji_uir; ir_at1 = vji_ir_in; end
      if (busy_on) begin cmd_valid = 1'b0; cmd_dr = dr; cmd_ir = ir; busy_on = 0; end
      if (vji_tck && !prev_tck) begin
        code = vji_uir ? 0 : vji_cdr ? 1 : vji_sdr ? 2 : vji_udr ? 3 : vji_rti ? 4 : 5;
        if (code == 5) proto_ok = 0; else edges[code]++;
        if (code < last_code) order_ok = 0;
        last_code = code;
        if (code == 2) begin
          sdr_edges++;
          if (sdr_edges == busy_at) begin
            cmd_valid = 1'b1; cmd_dr = ~dr; cmd_ir = ~ir; busy_on = 1;
          end
        end
      end
      prev_tck = vji_tck;
      if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) proto_ok = 0;
      if (vji_tdi && !vji_sdr) proto_ok = 0;
      if (cmd_ready && !rsp_valid) proto_ok = 0;
      if (vji_udr && !udr_seen) begin udr_seen = 1; udr_model = model_sr; end
      if (rsp_valid) begin rsp_cyc = n; rsp_val = rsp_data; break; end
    end
  endtask

  initial begin
    int          extra, sdr_cnt, r1;
    bit          prev, tck_ok;
    logic [37:0] snap, d1;

    model_init = 38'h2A_AAAA_AAAA;
    model_ld = 1'b1; model1_ld = 1'b1;
    #1;
    model_ld = 1'b0; model1_ld = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl_flags", {cmd_ready, vji_rti, vji_tck, vji_tdi, vji_ir_in, vji_uir,
                               vji_cdr, vji_sdr, vji_udr, rsp_valid}, {2'b11, 9'b0});
    check("reset_rsp_data", rsp_data, 38'h0);
    reset_n = 1'b1;
    tck_ok = 1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (vji_tck !== 1'b0 || cmd_ready !== 1'b1 || vji_rti !== 1'b1) tck_ok = 0;
    end
    check("idle_after_release", tck_ok, 1'b1);

    // Single command at defaults.
    run_cmd(2'b01, 38'h15_5555_5555, 0);
    check("A_rsp_cycle", rsp_cyc, 169);
    check("A_rsp_data", rsp_val, 38'h2A_AAAA_AAAA);
    check("A_model_at_udr", udr_model, 38'h15_5555_5555);
    check("A_edges_uir", edges[0], 1);
    check("A_edges_cdr", edges[1], 1);
    check("A_edges_sdr", edges[2], 38);
    check("A_edges_udr", edges[3], 1);
    check("A_edges_rti", edges[4], 1);
    check("A_flag_order", order_ok, 1'b1);
    check("A_protocol", proto_ok, 1'b1);
    check("A_uir_cycle1", uir_at1, 1'b1);
    check("A_ir_in", ir_at1, 2'b01);

    // Back-to-back: offered in the response cycle.
    run_cmd(2'b10, 38'h00_0000_0001, 0);
    check("B_uir_cycle1", uir_at1, 1'b1);
    check("B_ir_in", ir_at1, 2'b10);
    check("B_rsp_cycle", rsp_cyc, 169);
    check("B_rsp_data", rsp_val, 38'h15_5555_5555);
    check("B_model_at_udr", udr_model, 38'h00_0000_0001);
    check("B_protocol", proto_ok, 1'b1);

    // Busy ignore: a different command pulsed during SDR.
    @(posedge clk); #1;
    run_cmd(2'b01, 38'h0F_0F0F_0F0F, 10);
    check("C_rsp_cycle", rsp_cyc, 169);
    check("C_rsp_data", rsp_val, 38'h00_0000_0001);
    check("C_model_at_udr", udr_model, 38'h0F_0F0F_0F0F);
    check("C_protocol", proto_ok, 1'b1);
    extra = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) extra++;
    end
    check("C_no_extra_rsp", extra, 0);
    check("C_rsp_data_held", rsp_data, 38'h00_0000_0001);

    // Reset in the middle of SDR.
    cmd_ir = 2'b11; cmd_dr = 38'h3F_FFFF_FFFF; cmd_valid = 1'b1;
    sdr_cnt = 0; prev = 0;
    for (int n = 1; n <= 300 && sdr_cnt < 21; n++) begin
      @(posedge clk); #1;
      if (n == 1) cmd_valid = 1'b0;
      if (vji_tck && !prev && vji_sdr) sdr_cnt++;
      prev = vji_tck;
    end
    check("D_reached_bit20", sdr_cnt, 21);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("D_reset_ctrl_flags", {cmd_ready, vji_rti, vji_tck, vji_tdi, vji_ir_in, vji_uir,
                                 vji_cdr, vji_sdr, vji_udr, rsp_valid}, {2'b11, 9'b0});
    check("D_reset_rsp_data", rsp_data, 38'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    extra = 0;
    for (int n = 0; n < 180; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) extra++;
    end
    check("D_no_rsp_after_abort", extra, 0);
    snap = model_sr;
    run_cmd(2'b10, 38'h20_0000_0003, 0);
    check("E_rsp_cycle", rsp_cyc, 169);
    check("E_rsp_data", rsp_val, snap);
    check("E_model_at_udr", udr_model, 38'h20_0000_0003);
    check("E_ir_in", ir_at1, 2'b10);
    check("E_protocol", proto_ok, 1'b1);

    // TCK_DIV = 1 instance, same single-command scenario.
    check("F_ready", cmd_ready1, 1'b1);
    cmd_ir = 2'b01; cmd_dr = 38'h15_5555_5555; cmd_valid1 = 1'b1;
    r1 = -1; d1 = '0; tck_ok = 1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) cmd_valid1 = 1'b0;
      if (n <= 84 && vji_tck1 !== ((n % 2) == 0)) tck_ok = 0;
      if (rsp_valid1) begin r1 = n; d1 = rsp_data1; break; end
    end
    check("F_rsp_cycle", r1, 85);
    check("F_rsp_data", d1, 38'h2A_AAAA_AAAA);
    check("F_tck_toggle", tck_ok, 1'b1);
    check("F_model_final", model1_sr, 38'h15_5555_5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
